// File: rtl/address_register_unit_pkg.sv
// Shared types for the address register unit: PC operation encoding and the
// priority decode that selects one PC operation per cycle.
package address_register_unit_pkg;

  typedef enum logic [2:0] {
    PC_HOLD = 3'd0,
    PC_INC  = 3'd1,
    PC_REL  = 3'd2,
    PC_SET  = 3'd3,
    PC_CALL = 3'd4,
    PC_RET  = 3'd5
  } pc_op_e;

  // Return beats call beats set beats relative beats increment.
  function automatic pc_op_e pick_pc_op(input logic ret, input logic call, input logic set,
                                        input logic rel, input logic inc);
    pc_op_e op;
    if (ret) begin
      op = PC_RET;
    end else if (call) begin
      op = PC_CALL;
    end else if (set) begin
      op = PC_SET;
    end else if (rel) begin
      op = PC_REL;
    end else if (inc) begin
      op = PC_INC;
    end else begin
      op = PC_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/address_register_unit_return_address_stack.sv
// LIFO of return addresses. Push when full and pop when empty are ignored here;
// the owner decides how to flag them. Entries are not cleared by reset.
module return_address_stack
  import address_register_unit_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int LEVEL_W = $clog2(DEPTH + 1)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   push_data,
  output logic [WIDTH-1:0]   top_data,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty
);

  logic [WIDTH-1:0]   mem_r [DEPTH];
  logic [LEVEL_W-1:0] level_r;
  logic [PTR_W-1:0]   wr_idx_s;
  logic [PTR_W-1:0]   rd_idx_s;

  assign wr_idx_s = PTR_W'(level_r);
  assign rd_idx_s = PTR_W'(level_r - LEVEL_W'(1));
  assign full     = (level_r == LEVEL_W'(DEPTH));
  assign empty    = (level_r == {LEVEL_W{1'b0}});
  assign level    = level_r;
  assign top_data = mem_r[rd_idx_s];

  // Occupancy counter.
  always_ff @(posedge clock) begin
    if (!reset) begin
      level_r <= {LEVEL_W{1'b0}};
    end else if (push && !full) begin
      level_r <= level_r + LEVEL_W'(1);
    end else if (pop && !empty) begin
      level_r <= level_r - LEVEL_W'(1);
    end
  end

  // Entry storage.
  always_ff @(posedge clock) begin
    if (push && !full) begin
      mem_r[wr_idx_s] <= push_data;
    end
  end

endmodule

// File: rtl/address_register_unit.sv
// IR/MAR/JR/PC register group: byte-serial loads from the shared bus, PC sequencing
// with call/return through a return-address stack, and PC/MAR address muxing.
module address_register_unit
  import address_register_unit_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 16,
  parameter int STACK_DEPTH = 8,
  localparam int BYTES = ADDR_WIDTH / DATA_WIDTH,
  localparam int SEL_W = $clog2(BYTES),
  localparam int LEVEL_W = $clog2(STACK_DEPTH + 1)
) (
  input  logic                  clock,
  input  logic                  reset,
  inout  wire  [DATA_WIDTH-1:0] data_bus,
  input  logic [SEL_W-1:0]      byte_sel,
  input  logic                  ir_load,
  input  logic                  mar_load,
  input  logic                  jr_load,
  input  logic                  pc_increment,
  input  logic                  pc_set,
  input  logic                  pc_relative,
  input  logic                  pc_call,
  input  logic                  pc_return,
  input  logic                  pc_drive,
  input  logic                  addr_select,
  input  logic                  error_clear,
  output logic [ADDR_WIDTH-1:0] address_out,
  output logic [ADDR_WIDTH-1:0] pc_count,
  output logic [ADDR_WIDTH-1:0] ir_value,
  output logic [ADDR_WIDTH-1:0] mar_value,
  output logic [LEVEL_W-1:0]    stack_level,
  output logic                  stack_full,
  output logic                  stack_empty,
  output logic                  stack_error
);

  logic [ADDR_WIDTH-1:0] pc_r, ir_r, mar_r, jr_r;
  logic [ADDR_WIDTH-1:0] pc_next_s, ret_addr_s, offset_s, pc_plus1_s;
  logic [BYTES-1:0]      lane_hit_s;
  logic [DATA_WIDTH-1:0] drive_byte_s;
  logic                  stack_error_r, push_s, pop_s, err_set_s, full_s, empty_s;
  pc_op_e                op_s;

  // Byte-lane decode; out-of-range selects hit no lane, so loads drop and drive reads 0.
  always_comb begin
    lane_hit_s   = {BYTES{1'b0}};
    drive_byte_s = {DATA_WIDTH{1'b0}};
    for (int b = 0; b < BYTES; b++) begin
      lane_hit_s[b] = (byte_sel == SEL_W'(b));
      drive_byte_s  = drive_byte_s | ({DATA_WIDTH{lane_hit_s[b]}} & pc_r[b*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  assign data_bus   = pc_drive ? drive_byte_s : {DATA_WIDTH{1'bz}};
  assign pc_plus1_s = pc_r + ADDR_WIDTH'(1);
  assign offset_s   = {{(ADDR_WIDTH - DATA_WIDTH){data_bus[DATA_WIDTH-1]}}, data_bus};

  // PC next-state and stack control; set/call see JR before any same-cycle load.
  always_comb begin
    op_s      = pick_pc_op(pc_return, pc_call, pc_set, pc_relative, pc_increment);
    pc_next_s = pc_r;
    push_s    = 1'b0;
    pop_s     = 1'b0;
    err_set_s = 1'b0;
    case (op_s)
      PC_RET: begin
        if (empty_s) begin
          err_set_s = 1'b1;
        end else begin
          pop_s     = 1'b1;
          pc_next_s = ret_addr_s;
        end
      end
      PC_CALL: begin
        if (full_s) begin
          err_set_s = 1'b1;
        end else begin
          push_s    = 1'b1;
          pc_next_s = jr_r;
        end
      end
      PC_SET:  pc_next_s = jr_r;
      PC_REL:  pc_next_s = pc_r + offset_s;
      PC_INC:  pc_next_s = pc_plus1_s;
      default: pc_next_s = pc_r;
    endcase
  end

  // Register group update.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pc_r          <= {ADDR_WIDTH{1'b0}};
      ir_r          <= {ADDR_WIDTH{1'b0}};
      mar_r         <= {ADDR_WIDTH{1'b0}};
      jr_r          <= {ADDR_WIDTH{1'b0}};
      stack_error_r <= 1'b0;
    end else begin
      pc_r <= pc_next_s;
      if (err_set_s) begin
        stack_error_r <= 1'b1;
      end else if (error_clear) begin
        stack_error_r <= 1'b0;
      end
      for (int b = 0; b < BYTES; b++) begin
        if (lane_hit_s[b]) begin
          if (ir_load)  ir_r[b*DATA_WIDTH +: DATA_WIDTH]  <= data_bus;
          if (mar_load) mar_r[b*DATA_WIDTH +: DATA_WIDTH] <= data_bus;
          if (jr_load)  jr_r[b*DATA_WIDTH +: DATA_WIDTH]  <= data_bus;
        end
      end
    end
  end

  return_address_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (push_s),
    .pop       (pop_s),
    .push_data (pc_plus1_s),
    .top_data  (ret_addr_s),
    .level     (stack_level),
    .full      (full_s),
    .empty     (empty_s)
  );

  assign stack_full  = full_s;
  assign stack_empty = empty_s;
  assign stack_error = stack_error_r;
  assign pc_count    = pc_r;
  assign ir_value    = ir_r;
  assign mar_value   = mar_r;
  assign address_out = addr_select ? mar_r : pc_r;

endmodule

// File: tb/tb_address_register_unit.sv
// Bench for address_register_unit: a 16-bit instance checked every cycle against a
// queue-based reference model (directed then random), plus a 24-bit instance.
module tb_address_register_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // ---------------- 16-bit instance ----------------
  logic        reset;
  wire  [7:0]  data_bus;
  logic [7:0]  drv_val;
  logic        drv_en;
  logic [0:0]  byte_sel;
  logic        ir_load, mar_load, jr_load, pc_increment, pc_set, pc_relative;
  logic        pc_call, pc_return, pc_drive, addr_select, error_clear;
  logic [15:0] address_out, pc_count, ir_value, mar_value;
  logic [3:0]  stack_level;
  logic        stack_full, stack_empty, stack_error;

  assign data_bus = drv_en ? drv_val : 8'bz;

  address_register_unit dut (
    .clock(clock), .reset(reset), .data_bus(data_bus), .byte_sel(byte_sel),
    .ir_load(ir_load), .mar_load(mar_load), .jr_load(jr_load),
    .pc_increment(pc_increment), .pc_set(pc_set), .pc_relative(pc_relative),
    .pc_call(pc_call), .pc_return(pc_return), .pc_drive(pc_drive),
    .addr_select(addr_select), .error_clear(error_clear),
    .address_out(address_out), .pc_count(pc_count), .ir_value(ir_value),
    .mar_value(mar_value), .stack_level(stack_level), .stack_full(stack_full),
    .stack_empty(stack_empty), .stack_error(stack_error)
  );

  // ---------------- 24-bit instance ----------------
  logic        b_reset;
  wire  [7:0]  b_data_bus;
  logic [7:0]  b_drv_val;
  logic        b_drv_en;
  logic [1:0]  b_byte_sel;
  logic        b_ir_load, b_mar_load, b_jr_load, b_pc_increment, b_pc_set, b_pc_relative;
  logic        b_pc_call, b_pc_return, b_pc_drive, b_addr_select, b_error_clear;
  logic [23:0] b_address_out, b_pc_count, b_ir_value, b_mar_value;
  logic [3:0]  b_stack_level;
  logic        b_stack_full, b_stack_empty, b_stack_error;

  assign b_data_bus = b_drv_en ? b_drv_val : 8'bz;

  address_register_unit #(.DATA_WIDTH(8), .ADDR_WIDTH(24), .STACK_DEPTH(8)) dut24 (
    .clock(clock), .reset(b_reset), .data_bus(b_data_bus), .byte_sel(b_byte_sel),
    .ir_load(b_ir_load), .mar_load(b_mar_load), .jr_load(b_jr_load),
    .pc_increment(b_pc_increment), .pc_set(b_pc_set), .pc_relative(b_pc_relative),
    .pc_call(b_pc_call), .pc_return(b_pc_return), .pc_drive(b_pc_drive),
    .addr_select(b_addr_select), .error_clear(b_error_clear),
    .address_out(b_address_out), .pc_count(b_pc_count), .ir_value(b_ir_value),
    .mar_value(b_mar_value), .stack_level(b_stack_level), .stack_full(b_stack_full),
    .stack_empty(b_stack_empty), .stack_error(b_stack_error)
  );

  // ---------------- reference model (16-bit, depth 8) ----------------
  logic [15:0] m_pc, m_ir, m_mar, m_jr;
  logic [15:0] m_stack[$];
  logic        m_err;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [15:0] v, input int sel);
    return v[8*sel +: 8];
  endfunction

  task automatic model_step();
    logic [7:0]  bus;
    logic [15:0] jr_old, mask, nv;
    logic        new_err;
    int          sh;
    bus = pc_drive ? byte_of(m_pc, int'(byte_sel)) : drv_val;
    if (!reset) begin
      m_pc = 16'h0; m_ir = 16'h0; m_mar = 16'h0; m_jr = 16'h0;
      m_stack.delete();
      m_err = 1'b0;
    end else begin
      jr_old  = m_jr;
      new_err = 1'b0;
      if (pc_return) begin
        if (m_stack.size() == 0) new_err = 1'b1;
        else m_pc = m_stack.pop_back();
      end else if (pc_call) begin
        if (m_stack.size() == 8) new_err = 1'b1;
        else begin
          m_stack.push_back(m_pc + 16'd1);
          m_pc = jr_old;
        end
      end else if (pc_set) begin
        m_pc = jr_old;
      end else if (pc_relative) begin
        m_pc = m_pc + {{8{bus[7]}}, bus};
      end else if (pc_increment) begin
        m_pc = m_pc + 16'd1;
      end
      m_err = new_err ? 1'b1 : (error_clear ? 1'b0 : m_err);
      sh   = 8 * int'(byte_sel);
      mask = 16'h00FF << sh;
      nv   = 16'(bus) << sh;
      if (ir_load)  m_ir  = (m_ir  & ~mask) | nv;
      if (mar_load) m_mar = (m_mar & ~mask) | nv;
      if (jr_load)  m_jr  = (m_jr  & ~mask) | nv;
    end
  endtask

  task automatic compare_all();
    chk("pc_count", 32'(pc_count), 32'(m_pc));
    chk("ir_value", 32'(ir_value), 32'(m_ir));
    chk("mar_value", 32'(mar_value), 32'(m_mar));
    chk("address_out", 32'(address_out), 32'(addr_select ? m_mar : m_pc));
    chk("stack_level", 32'(stack_level), 32'(m_stack.size()));
    chk("stack_full", 32'(stack_full), 32'(m_stack.size() == 8));
    chk("stack_empty", 32'(stack_empty), 32'(m_stack.size() == 0));
    chk("stack_error", 32'(stack_error), 32'(m_err));
  endtask

  task automatic idle();
    reset = 1'b1; drv_val = 8'h00; byte_sel = 1'b0;
    ir_load = 1'b0; mar_load = 1'b0; jr_load = 1'b0; pc_increment = 1'b0;
    pc_set = 1'b0; pc_relative = 1'b0; pc_call = 1'b0; pc_return = 1'b0;
    pc_drive = 1'b0; addr_select = 1'b0; error_clear = 1'b0;
  endtask

  task automatic cycle();
    drv_en = !pc_drive;
    #1;
    if (pc_drive) chk("bus_drive", 32'(data_bus), 32'(byte_of(m_pc, int'(byte_sel))));
    model_step();
    @(posedge clock);
    #1;
    compare_all();
  endtask

  task automatic set_jr(input logic [15:0] v);
    idle(); jr_load = 1'b1;
    byte_sel = 1'b0; drv_val = v[7:0];  cycle();
    byte_sel = 1'b1; drv_val = v[15:8]; cycle();
    idle();
  endtask

  task automatic b_idle();
    b_reset = 1'b1; b_drv_val = 8'h00; b_drv_en = 1'b1; b_byte_sel = 2'd0;
    b_ir_load = 1'b0; b_mar_load = 1'b0; b_jr_load = 1'b0; b_pc_increment = 1'b0;
    b_pc_set = 1'b0; b_pc_relative = 1'b0; b_pc_call = 1'b0; b_pc_return = 1'b0;
    b_pc_drive = 1'b0; b_addr_select = 1'b0; b_error_clear = 1'b0;
  endtask

  task automatic b_cycle();
    b_drv_en = !b_pc_drive;
    @(posedge clock);
    #1;
  endtask

  initial begin
    idle(); b_idle(); drv_en = 1'b1;

    // Reset both instances
    reset = 1'b0; b_reset = 1'b0;
    cycle(); cycle();
    idle(); b_reset = 1'b1;
    chk("rst_pc", 32'(pc_count), 32'h0);
    chk("rst_empty", 32'(stack_empty), 32'h1);

    // 1: JR byte loads, set, increments
    set_jr(16'h1234);
    pc_set = 1'b1; cycle(); idle();
    chk("t1_set", 32'(pc_count), 32'h1234);
    pc_increment = 1'b1; cycle(); cycle(); idle();
    chk("t1_inc2", 32'(pc_count), 32'h1236);

    // 2: increment wrap, negative and positive relative branch
    set_jr(16'hFFFF); pc_set = 1'b1; cycle(); idle();
    pc_increment = 1'b1; cycle(); idle();
    chk("t2_wrap", 32'(pc_count), 32'h0000);
    set_jr(16'h0010); pc_set = 1'b1; cycle(); idle();
    pc_relative = 1'b1; drv_val = 8'hFE; cycle(); idle();
    chk("t2_rel_neg", 32'(pc_count), 32'h000E);
    pc_relative = 1'b1; drv_val = 8'h7F; cycle(); idle();
    chk("t2_rel_pos", 32'(pc_count), 32'h008D);

    // 3: call / return
    set_jr(16'h0100); pc_set = 1'b1; cycle(); idle();
    set_jr(16'h2000); pc_call = 1'b1; cycle(); idle();
    chk("t3_call_pc", 32'(pc_count), 32'h2000);
    chk("t3_call_lvl", 32'(stack_level), 32'h1);
    pc_return = 1'b1; cycle(); idle();
    chk("t3_ret_pc", 32'(pc_count), 32'h0101);
    chk("t3_ret_empty", 32'(stack_empty), 32'h1);

    // 4: overflow, clear, underflow, clear colliding with new error
    set_jr(16'h0300);
    pc_call = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    chk("t4_full", 32'(stack_full), 32'h1);
    cycle(); idle();
    chk("t4_ovf_pc", 32'(pc_count), 32'h0300);
    chk("t4_ovf_err", 32'(stack_error), 32'h1);
    error_clear = 1'b1; cycle(); idle();
    chk("t4_clear", 32'(stack_error), 32'h0);
    pc_return = 1'b1;
    for (int i = 0; i < 8; i++) cycle();
    chk("t4_unwound", 32'(pc_count), 32'h0102);
    cycle(); idle();
    chk("t4_udf_err", 32'(stack_error), 32'h1);
    chk("t4_udf_pc", 32'(pc_count), 32'h0102);
    pc_return = 1'b1; error_clear = 1'b1; cycle(); idle();
    chk("t4_err_wins", 32'(stack_error), 32'h1);
    error_clear = 1'b1; cycle(); idle();

    // 5: priority with same-cycle JR load, PC drive into IR, reset mid-stack
    set_jr(16'h4000); pc_call = 1'b1; cycle(); idle();
    pc_return = 1'b1; pc_increment = 1'b1; jr_load = 1'b1; drv_val = 8'h55; cycle(); idle();
    chk("t5_prio_pc", 32'(pc_count), 32'h0103);
    pc_set = 1'b1; cycle(); idle();
    chk("t5_jr_byte", 32'(pc_count), 32'h4055);
    pc_drive = 1'b1; byte_sel = 1'b1; ir_load = 1'b1; cycle(); idle();
    chk("t5_drive_ir", 32'(ir_value), 32'h4000);
    pc_call = 1'b1; cycle(); cycle(); idle();
    reset = 1'b0; cycle(); idle();
    chk("t5_rst_lvl", 32'(stack_level), 32'h0);
    chk("t5_rst_pc", 32'(pc_count), 32'h0);

    // Random traffic against the model
    for (int n = 0; n < 400; n++) begin
      idle();
      reset        = ($urandom_range(0, 49) != 0);
      byte_sel     = 1'($urandom_range(0, 1));
      drv_val      = 8'($urandom_range(0, 255));
      ir_load      = ($urandom_range(0, 3) == 0);
      mar_load     = ($urandom_range(0, 3) == 0);
      jr_load      = ($urandom_range(0, 2) == 0);
      pc_increment = ($urandom_range(0, 2) == 0);
      pc_set       = ($urandom_range(0, 7) == 0);
      pc_relative  = ($urandom_range(0, 5) == 0);
      pc_call      = ($urandom_range(0, 4) == 0);
      pc_return    = ($urandom_range(0, 5) == 0);
      pc_drive     = ($urandom_range(0, 5) == 0);
      addr_select  = 1'($urandom_range(0, 1));
      error_clear  = ($urandom_range(0, 7) == 0);
      cycle();
    end
    idle(); drv_en = 1'b1;

    // 6: 24-bit instance
    chk("b_rst_pc", 32'(b_pc_count), 32'h0);
    b_mar_load = 1'b1;
    b_byte_sel = 2'd0; b_drv_val = 8'hAB; b_cycle();
    b_byte_sel = 2'd1; b_drv_val = 8'hCD; b_cycle();
    b_byte_sel = 2'd2; b_drv_val = 8'hEF; b_cycle();
    b_mar_load = 1'b0; b_addr_select = 1'b1; #1;
    chk("b_mar_addr", 32'(b_address_out), 32'hEFCDAB);
    b_mar_load = 1'b1; b_byte_sel = 2'd3; b_drv_val = 8'h99; b_cycle(); b_mar_load = 1'b0;
    chk("b_sel3_ignored", 32'(b_mar_value), 32'hEFCDAB);
    b_jr_load = 1'b1; b_byte_sel = 2'd2; b_drv_val = 8'h5A; b_cycle(); b_jr_load = 1'b0;
    b_pc_set = 1'b1; b_cycle(); b_pc_set = 1'b0;
    b_addr_select = 1'b0; #1;
    chk("b_pc_addr", 32'(b_address_out), 32'h5A0000);
    b_drv_en = 1'b0; b_pc_drive = 1'b1; b_byte_sel = 2'd2; #1;
    chk("b_drive_sel2", 32'(b_data_bus), 32'h5A);
    b_byte_sel = 2'd3; #1;
    chk("b_drive_sel3", 32'(b_data_bus), 32'h00);
    b_byte_sel = 2'd2; b_ir_load = 1'b1; b_cycle(); b_ir_load = 1'b0; b_pc_drive = 1'b0;
    chk("b_drive_ir", 32'(b_ir_value), 32'h5A0000);
    b_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
